// File: rtl/cdb_arbiter_if.sv
// Result/CDB bundle between the ALU/LSU result producers and cdb_arbiter.
// master = result producers and CDB consumers; slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
);
  logic                _alu_res_ready;
  logic [ROB_ID_W-1:0] _alu_res_rob_id;
  logic [DATA_W-1:0]   _alu_res_value;
  logic                _alu_res_full;
  logic                _ls_res_ready;
  logic [ROB_ID_W-1:0] _ls_res_rob_id;
  logic [DATA_W-1:0]   _ls_res_value;
  logic                _ls_res_full;
  logic                _cdb_ready;
  logic [ROB_ID_W-1:0] _cdb_rob_id;
  logic [DATA_W-1:0]   _cdb_value;
  logic                _cdb_src;
  logic                _err_overflow;

  modport master (
    output _alu_res_ready, _alu_res_rob_id, _alu_res_value,
    output _ls_res_ready, _ls_res_rob_id, _ls_res_value,
    input  _alu_res_full, _ls_res_full,
    input  _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_src, _err_overflow
  );

  modport slave (
    input  _alu_res_ready, _alu_res_rob_id, _alu_res_value,
    input  _ls_res_ready, _ls_res_rob_id, _ls_res_value,
    output _alu_res_full, _ls_res_full,
    output _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_src, _err_overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining per-source ALU/LSU result FIFOs onto a registered CDB.
// Optional macro CDB_BYPASS_EN: an incoming result into an empty FIFO may go straight to the CDB.
module cdb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         _clear,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(DEPTH - 1);

  // Index 0 = ALU, index 1 = LSU throughout; matches the _cdb_src encoding.
  logic [ROB_ID_W-1:0] tag_mem [2][DEPTH];
  logic [DATA_W-1:0]   val_mem [2][DEPTH];
  logic [PTR_W-1:0]    head    [2];
  logic [PTR_W-1:0]    tail    [2];
  logic [CNT_W-1:0]    count   [2];
  logic                rr_ptr;
  logic                err_ovf;

  logic                vld_p1;
  logic                src_p1;
  logic [ROB_ID_W-1:0] tag_p1;
  logic [DATA_W-1:0]   val_p1;

  logic [1:0]          in_vld;
  logic [ROB_ID_W-1:0] in_tag [2];
  logic [DATA_W-1:0]   in_val [2];
  logic                active;
  logic [1:0]          empty, req, grant, byp, pop, wr, ovf;
  logic                win;
  logic [ROB_ID_W-1:0] win_tag;
  logic [DATA_W-1:0]   win_val;

  assign in_vld    = {bus._ls_res_ready, bus._alu_res_ready};
  assign in_tag[0] = bus._alu_res_rob_id;
  assign in_tag[1] = bus._ls_res_rob_id;
  assign in_val[0] = bus._alu_res_value;
  assign in_val[1] = bus._ls_res_value;
  assign active    = rdy_in && !_clear;

  // Stage p0: request, grant, bypass and FIFO pointer decisions
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      empty[s] = (count[s] == '0);
`ifdef CDB_BYPASS_EN
      req[s]   = !empty[s] || in_vld[s];
`else
      req[s]   = !empty[s];
`endif
    end
    grant[0] = active && req[0] && (!req[1] || !rr_ptr);
    grant[1] = active && req[1] && (!req[0] || rr_ptr);
    win      = grant[1];
    for (int s = 0; s < 2; s++) begin
`ifdef CDB_BYPASS_EN
      byp[s] = grant[s] && empty[s];
`else
      byp[s] = 1'b0;
`endif
      pop[s] = grant[s] && !byp[s];
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      wr[s]  = active && in_vld[s] && !byp[s] && ((count[s] != CNT_FULL) || pop[s]);
      ovf[s] = active && in_vld[s] && !byp[s] && (count[s] == CNT_FULL) && !pop[s];
    end
    win_tag = byp[win] ? in_tag[win] : tag_mem[win][head[win]];
    win_val = byp[win] ? in_val[win] : val_mem[win][head[win]];
  end

  // Stage p1: FIFO bookkeeping and the registered CDB broadcast
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      rr_ptr  <= 1'b0;
      err_ovf <= 1'b0;
      vld_p1  <= 1'b0;
      src_p1  <= 1'b0;
      tag_p1  <= '0;
      val_p1  <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        for (int s = 0; s < 2; s++) begin
          head[s]  <= '0;
          tail[s]  <= '0;
          count[s] <= '0;
        end
        rr_ptr <= 1'b0;
        vld_p1 <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (wr[s])  tail[s] <= tail[s] + PTR_W'(1);
          if (pop[s]) head[s] <= head[s] + PTR_W'(1);
          if (wr[s] && !pop[s])      count[s] <= count[s] + CNT_W'(1);
          else if (pop[s] && !wr[s]) count[s] <= count[s] - CNT_W'(1);
        end
        if (req[0] && req[1]) rr_ptr <= ~win;
        vld_p1 <= |grant;
        if (|grant) begin
          tag_p1 <= win_tag;
          val_p1 <= win_val;
          src_p1 <= win;
        end
        if (|ovf) err_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int s = 0; s < 2; s++) begin
      if (wr[s]) begin
        tag_mem[s][tail[s]] <= in_tag[s];
        val_mem[s][tail[s]] <= in_val[s];
      end
    end
  end

  assign bus._alu_res_full = (count[0] >= CNT_HIGH);
  assign bus._ls_res_full  = (count[1] >= CNT_HIGH);
  assign bus._cdb_ready    = vld_p1;
  assign bus._cdb_rob_id   = tag_p1;
  assign bus._cdb_value    = val_p1;
  assign bus._cdb_src      = src_p1;
  assign bus._err_overflow = err_ovf;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-source scoreboard queues plus a small arbitration model.
module tb_cdb_arbiter;
  localparam int DEPTH    = 4;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [ROB_ID_W-1:0] tag;
    logic [DATA_W-1:0]   val;
  } ent_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic _clear;

  cdb_arbiter_if #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    ._clear (_clear),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  ent_t qa[$];
  ent_t ql[$];
  logic [ROB_ID_W-1:0] seen[$];
  logic                m_rr, m_ready, m_src, m_err;
  logic [ROB_ID_W-1:0] m_tag;
  logic [DATA_W-1:0]   m_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string where);
    logic ea, el;
    ea = (qa.size() >= DEPTH - 1);
    el = (ql.size() >= DEPTH - 1);
    chk({where, ".ready"}, bus._cdb_ready, m_ready);
    chk({where, ".tag"},   bus._cdb_rob_id, m_tag);
    chk({where, ".value"}, bus._cdb_value, m_val);
    chk({where, ".src"},   bus._cdb_src, m_src);
    chk({where, ".alu_full"}, bus._alu_res_full, ea);
    chk({where, ".ls_full"},  bus._ls_res_full, el);
    chk({where, ".overflow"}, bus._err_overflow, m_err);
    if (bus._cdb_ready === 1'b1) seen.push_back(bus._cdb_rob_id);
  endtask

  task automatic model_reset();
    qa.delete();
    ql.delete();
    m_rr = 1'b0; m_ready = 1'b0; m_src = 1'b0; m_err = 1'b0;
    m_tag = '0;  m_val = '0;
  endtask

  // Drive one cycle, predict the edge's effect, then sample 1 time unit after the edge.
  task automatic step(input string name, input bit rdy, input bit clr,
                      input bit av, input int at, input int aval,
                      input bit lv, input int lt, input int lval);
    ent_t ia, il, e;
    int   na, nl;
    bit   ra, rl, wa, wl, ba, bl;
    ia.tag = at[ROB_ID_W-1:0]; ia.val = aval;
    il.tag = lt[ROB_ID_W-1:0]; il.val = lval;
    rdy_in = rdy;
    _clear = clr;
    bus._alu_res_ready  = av;
    bus._alu_res_rob_id = ia.tag;
    bus._alu_res_value  = ia.val;
    bus._ls_res_ready   = lv;
    bus._ls_res_rob_id  = il.tag;
    bus._ls_res_value   = il.val;
    if (rdy && clr) begin
      qa.delete();
      ql.delete();
      m_ready = 1'b0;
      m_rr    = 1'b0;
    end else if (rdy) begin
      na = qa.size();
      nl = ql.size();
      ra = (na != 0) || (BYP && av);
      rl = (nl != 0) || (BYP && lv);
      wa = ra && (!rl || !m_rr);
      wl = rl && !wa;
      ba = BYP && wa && (na == 0);
      bl = BYP && wl && (nl == 0);
      if (ra && rl) m_rr = wa;
      if (wa) e = ba ? ia : qa.pop_front();
      if (wl) e = bl ? il : ql.pop_front();
      m_ready = wa || wl;
      if (wa || wl) begin
        m_tag = e.tag;
        m_val = e.val;
        m_src = wl;
      end
      if (av && !ba) begin
        if (na == DEPTH && !wa) m_err = 1'b1;
        else qa.push_back(ia);
      end
      if (lv && !bl) begin
        if (nl == DEPTH && !wl) m_err = 1'b1;
        else ql.push_back(il);
      end
    end
    @(posedge clk_in);
    #1;
    check_outs(name);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    _clear = 1'b0;
    bus._alu_res_ready = 1'b0; bus._alu_res_rob_id = '0; bus._alu_res_value = '0;
    bus._ls_res_ready  = 1'b0; bus._ls_res_rob_id  = '0; bus._ls_res_value  = '0;
    model_reset();
    #12;
    check_outs("reset");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Single uncontested ALU result
    step("alu_single_e0", 1, 0, 1, 3, 'h11, 0, 0, 0);
`ifdef CDB_BYPASS_EN
    chk("alu_single_lat.ready", bus._cdb_ready, 1'b1);
    chk("alu_single_lat.tag", bus._cdb_rob_id, 3);
`endif
    step("alu_single_e1", 1, 0, 0, 0, 0, 0, 0, 0);
`ifndef CDB_BYPASS_EN
    chk("alu_single_lat.ready", bus._cdb_ready, 1'b1);
    chk("alu_single_lat.tag", bus._cdb_rob_id, 3);
`endif
    idle("alu_single_drain", 2);

    // Contention: both sources push two results back to back
    seen.delete();
    step("contend0", 1, 0, 1, 1, 'hA001, 1, 9, 'hB009);
    step("contend1", 1, 0, 1, 2, 'hA002, 1, 10, 'hB010);
    idle("contend_drain", 4);
    chk("contend.count", seen.size(), 4);
    chk("contend.order0", seen[0], 1);
    chk("contend.order1", seen[1], 9);
    chk("contend.order2", seen[2], 2);
    chk("contend.order3", seen[3], 10);
    step("contend_again", 1, 0, 1, 4, 'hA004, 1, 12, 'hB012);
    idle("contend_again_drain", 3);

    // Backpressure and overflow: both sources push every cycle
    for (int i = 0; i < 10; i++)
      step("bp_push", 1, 0, 1, i, 'hC000 + i, 1, 16 + i, 'hD000 + i);
    chk("bp.overflow_set", bus._err_overflow, 1'b1);
    idle("bp_drain", 10);

    // Flush with entries queued; inputs in the flush cycle are dropped
    for (int i = 0; i < 3; i++)
      step("flush_fill", 1, 0, 1, 20 + i, 'hE000 + i, 1, 24 + i, 'hF000 + i);
    step("flush", 1, 1, 1, 30, 'hEEEE, 1, 31, 'hFFFF);
    chk("flush.ready", bus._cdb_ready, 1'b0);
    chk("flush.alu_full", bus._alu_res_full, 1'b0);
    chk("flush.ls_full", bus._ls_res_full, 1'b0);
    chk("flush.overflow_kept", bus._err_overflow, 1'b1);
    idle("flush_after", 3);

    // Pause with entries queued; inputs held during pause must be ignored
    for (int i = 0; i < 3; i++)
      step("pause_fill", 1, 0, 1, 5 + i, 'h5000 + i, 1, 12 + i, 'h6000 + i);
    for (int i = 0; i < 3; i++)
      step("pause", 0, 0, 1, 29, 'h9999, 1, 28, 'h8888);
    idle("pause_resume", 6);

    // Asynchronous reset mid-cycle
    step("arst_fill0", 1, 0, 1, 2, 'h7002, 1, 3, 'h7003);
    step("arst_fill1", 1, 0, 1, 4, 'h7004, 1, 6, 'h7006);
    chk("arst.pre_ready", bus._cdb_ready, 1'b1);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    check_outs("async_reset");
    @(negedge clk_in);
    rst_in = 1'b0;
    idle("post_reset", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
